// File: rtl/wdg_window_cntr.sv
// Windowed watchdog down-counter with tick prescaler, early-kick detection,
// and two-stage expiry: a bark interrupt followed by a sticky bite reset request.
//
// Ports:
//   mtick_clk    : single clock (mtime tick domain)
//   res_n        : synchronous active-low reset
//   en           : watchdog enable (level)
//   kick         : software service request, evaluated every cycle
//   init_cnt     : timeout reload value
//   win_cnt      : window threshold; a kick is legal only when count_wdg <= win_cnt
//   bark_cnt     : grace count loaded on entry to BARK
//   presc_div    : a tick occurs every presc_div+1 clocks
//   count_wdg    : current count
//   state        : 0=IDLE, 1=RUN, 2=BARK, 3=BITE
//   bark         : high while in BARK
//   bite         : high in BITE; sticky until reset
//   early_kick   : one-cycle pulse in the first BITE cycle after a closed-window kick
module wdg_window_cntr #(
    parameter int WIDTH       = 16,
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   mtick_clk,
    input  logic                   res_n,
    input  logic                   en,
    input  logic                   kick,
    input  logic [WIDTH-1:0]       init_cnt,
    input  logic [WIDTH-1:0]       win_cnt,
    input  logic [WIDTH-1:0]       bark_cnt,
    input  logic [PRESC_WIDTH-1:0] presc_div,
    output logic [WIDTH-1:0]       count_wdg,
    output logic [1:0]             state,
    output logic                   bark,
    output logic                   bite,
    output logic                   early_kick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_BARK = 2'd2,
        ST_BITE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                   bark_q, bark_d;
    logic                   bite_q, bite_d;
    logic                   early_q, early_d;

    logic tick;
    logic cnt_zero;
    logic win_open;

    // The prescaler only advances while the count is live (RUN/BARK).
    assign tick     = ((state_q == ST_RUN) || (state_q == ST_BARK))
                      && (presc_q == presc_div);
    assign cnt_zero = (cnt_q == '0);
    assign win_open = (cnt_q <= win_cnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = '0;
        early_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Track the reload value so RUN starts from a fresh init_cnt.
                cnt_d = init_cnt;
                if (en) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = init_cnt;
                    presc_d = '0;
                end else if (kick) begin
                    presc_d = '0;
                    if (win_open) begin
                        cnt_d = init_cnt;
                    end else begin
                        // Kick arrived while the window was still closed.
                        state_d = ST_BITE;
                        cnt_d   = '0;
                        early_d = 1'b1;
                    end
                end else if (tick) begin
                    if (cnt_zero) begin
                        state_d = ST_BARK;
                        cnt_d   = bark_cnt;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            ST_BARK: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = init_cnt;
                    presc_d = '0;
                end else if (kick) begin
                    // Any kick rescues the watchdog from BARK.
                    state_d = ST_RUN;
                    cnt_d   = init_cnt;
                    presc_d = '0;
                end else if (tick) begin
                    if (cnt_zero) begin
                        state_d = ST_BITE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            ST_BITE: begin
                // Terminal until reset.
                cnt_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        bark_d = (state_d == ST_BARK);
        bite_d = (state_d == ST_BITE);
    end

    always_ff @(posedge mtick_clk) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            bark_q  <= 1'b0;
            bite_q  <= 1'b0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            bark_q  <= bark_d;
            bite_q  <= bite_d;
            early_q <= early_d;
        end
    end

    assign count_wdg  = cnt_q;
    assign state      = state_q;
    assign bark       = bark_q;
    assign bite       = bite_q;
    assign early_kick = early_q;

endmodule

// File: doc/wdg_window_cntr.md
Name: wdg_window_cntr

Overview:
- Parametrised windowed watchdog down-counter; successor to the plain reload-at-zero watchdog counter.
- Adds the following on top of a plain down-counter:
  - programmable tick prescaler;
  - enable;
  - software kick, with early-kick (closed-window) detection;
  - two-stage expiry: bark (interrupt) and then bite (reset request).
- Sits between the mtime tick source and the interrupt/reset controller.

Parameters:
- WIDTH, 16, width of all count and threshold values.
- PRESC_WIDTH, 4, width of the prescaler divider.

Ports:
- mtick_clk  in  1  single clock (mtime tick domain).
- res_n  in  1  reset, synchronous, active-low.
- en  in  1  watchdog enable (level).
- kick  in  1  service request, 1-cycle pulse (level treated per cycle).
- init_cnt  in  WIDTH  timeout reload value.
- win_cnt  in  WIDTH  window threshold; kick is legal only when count_wdg <= win_cnt.
- bark_cnt  in  WIDTH  grace count loaded on entry to BARK.
- presc_div  in  PRESC_WIDTH  tick every presc_div+1 clocks.
- count_wdg  out  WIDTH  current count.
- state  out  2  0=IDLE, 1=RUN, 2=BARK, 3=BITE.
- bark  out  1  high while in BARK.
- bite  out  1  high in BITE; sticky until reset.
- early_kick  out  1  1-cycle pulse on a closed-window kick.

Behaviour:
- Reset:
  - Synchronous: applied on the mtick_clk edge with res_n=0.
  - state=IDLE, count_wdg=0, prescaler=0, bark=0, bite=0, early_kick=0.
- Prescaler:
  - Internal counter counts 0..presc_div.
  - tick=1 in the cycle the prescaler equals presc_div; the prescaler then wraps to 0.
  - presc_div=0 gives a tick every cycle.
  - Runs only in RUN and BARK.
  - Cleared in IDLE, in BITE, and on every reload.
- IDLE:
  - count_wdg<=init_cnt every cycle.
  - en=1 -> RUN next cycle, prescaler cleared.
- RUN:
  - en=0 -> IDLE. Has priority over everything except reset.
  - kick with count_wdg<=win_cnt -> count_wdg<=init_cnt, prescaler cleared, stay in RUN.
  - kick with count_wdg>win_cnt -> BITE next cycle; early_kick=1 for that one cycle.
  - tick with count_wdg!=0 -> decrement by 1.
  - tick with count_wdg==0 -> BARK, count_wdg<=bark_cnt.
  - Kick and tick in the same cycle: kick wins, no decrement.
  - win_cnt>=init_cnt means the window is always open.
- BARK:
  - bark=1.
  - en=0 -> IDLE.
  - Any kick (window not checked) -> RUN, count_wdg<=init_cnt, prescaler cleared.
  - tick with count_wdg!=0 -> decrement.
  - tick with count_wdg==0 -> BITE.
  - bark_cnt=0 -> BITE on the first tick after entry.
- BITE:
  - Terminal state: bite=1, bark=0, count_wdg held at 0.
  - kick and en ignored; exit only via res_n=0.
- Output timing:
  - All outputs are registered.
  - state, bark and bite change in the same cycle as the transition edge.
  - early_kick is asserted in the first BITE cycle only.
- Input sampling:
  - init_cnt and bark_cnt are sampled only at load events.
  - win_cnt is compared combinationally in the kick cycle.
  - presc_div is compared live; a change takes effect at the next comparison.
- Arithmetic:
  - Unsigned WIDTH-bit values.
  - Decrement never wraps: the zero case is handled by the transition.
- Reset mid-operation: reset in any state, including BITE, returns to IDLE with the reset values above.

Test Plan:
- Plain timeout:
  - Stimulus: presc_div=0, init_cnt=5, bark_cnt=3, en=1, no kick.
  - Response: count 5..0 in RUN; BARK with count 3..0, bark=1; BITE at cycle 1+6+4; bite=1 and count=0 held.
- Legal kick:
  - Stimulus: init_cnt=10, win_cnt=4, kick when count=3.
  - Response: count reloads to 10 next cycle, state=RUN, early_kick=0.
- Early kick:
  - Stimulus: init_cnt=10, win_cnt=4, kick when count=7.
  - Response: state=BITE next cycle, early_kick=1 for exactly 1 cycle, bite stays 1.
- Prescaler plus simultaneous kick and tick:
  - Stimulus: presc_div=3, init_cnt=8, win_cnt=8.
  - Response, no kick: count decrements once every 4 clocks.
  - Response, kick on a tick cycle: count reloads to 8, no decrement, next tick 4 clocks later.
- Bark recovery and disable:
  - Stimulus: in BARK, kick.
  - Response: RUN with count=init_cnt, bark=0.
  - Stimulus: later, en=0 in RUN.
  - Response: IDLE, count tracks init_cnt.
  - Stimulus: en=0 in BITE.
  - Response: stays BITE.
- Reset mid-operation:
  - Stimulus: res_n=0 for 1 cycle during BARK, and again during BITE.
  - Response: next cycle state=IDLE, count=0, bark=bite=early_kick=0.
